// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared opcodes, FSM state encoding and opcode classes for the
//            ALU issue/sequencing stage.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDC = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SUBB = 5'd3;
    localparam logic [4:0] OP_MUL  = 5'd4;
    localparam logic [4:0] OP_FADD = 5'd5;
    localparam logic [4:0] OP_FSUB = 5'd6;
    localparam logic [4:0] OP_FMUL = 5'd7;
    localparam logic [4:0] OP_AND  = 5'd8;
    localparam logic [4:0] OP_OR   = 5'd9;
    localparam logic [4:0] OP_XOR  = 5'd10;
    localparam logic [4:0] OP_NAND = 5'd11;
    localparam logic [4:0] OP_NOR  = 5'd12;
    localparam logic [4:0] OP_XNOR = 5'd13;
    localparam logic [4:0] OP_NOT  = 5'd14;
    localparam logic [4:0] OP_NEG  = 5'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CLS_INT     = 3'd0,
        CLS_MUL     = 3'd1,
        CLS_FADD    = 3'd2,
        CLS_FMUL    = 3'd3,
        CLS_LOGIC   = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t cls;
        cls = CLS_ILLEGAL;
        if (op <= OP_SUBB)                      cls = CLS_INT;
        else if (op == OP_MUL)                  cls = CLS_MUL;
        else if (op == OP_FADD || op == OP_FSUB) cls = CLS_FADD;
        else if (op == OP_FMUL)                 cls = CLS_FMUL;
        else if (op <= OP_NEG)                  cls = CLS_LOGIC;
        return cls;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl_if
// Purpose  : Request, ALU-drive and result signals of the ALU issue stage.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_seq_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_opcode;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_enable;
    logic [31:0] alu_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;

    // master: decode stage, ALU and result consumer around the issue stage
    modport master (
        output req_valid, req_opcode, req_a, req_b, alu_out, res_ready,
        input  req_ready, alu_opcode, alu_a, alu_b, alu_enable,
               res_valid, res_data, res_err
    );

    modport slave (
        input  req_valid, req_opcode, req_a, req_b, alu_out, res_ready,
        output req_ready, alu_opcode, alu_a, alu_b, alu_enable,
               res_valid, res_data, res_err
    );

endinterface
`default_nettype wire

// File: rtl/alu_lat_lookup.sv
`default_nettype none
// ============================================================================
// Module   : alu_lat_lookup
// Purpose  : Combinational opcode -> latency (cycles) and illegal-opcode flag.
// Revision : 1.0 - initial release
// ============================================================================
module alu_lat_lookup
    import alu_pkg::*;
#(
    parameter int LAT_INT   = 1,
    parameter int LAT_MUL   = 4,
    parameter int LAT_FADD  = 3,
    parameter int LAT_FMUL  = 4,
    parameter int LAT_LOGIC = 1
) (
    input  wire logic [4:0] opcode,
    output logic      [3:0] lat,
    output logic            illegal
);

    // The 4-bit down-counter can only express latencies of 1..15 cycles.
    generate
        if (LAT_INT   < 1 || LAT_INT   > 15 ||
            LAT_MUL   < 1 || LAT_MUL   > 15 ||
            LAT_FADD  < 1 || LAT_FADD  > 15 ||
            LAT_FMUL  < 1 || LAT_FMUL  > 15 ||
            LAT_LOGIC < 1 || LAT_LOGIC > 15) begin : g_lat_range_err
            $error("alu_lat_lookup: every LAT_* parameter must be in 1..15");
        end
    endgenerate

    always_comb begin
        lat     = 4'd1;
        illegal = 1'b0;
        case (op_class(opcode))
            CLS_INT:   lat = 4'(LAT_INT);
            CLS_MUL:   lat = 4'(LAT_MUL);
            CLS_FADD:  lat = 4'(LAT_FADD);
            CLS_FMUL:  lat = 4'(LAT_FMUL);
            CLS_LOGIC: lat = 4'(LAT_LOGIC);
            default:   illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Purpose  : Issue/sequencing stage for the non-pipelined ALU; one op in
//            flight. Optional macro ALU_PERF_CNT_EN adds perf_ops/perf_busy.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int LAT_INT   = 1,
    parameter int LAT_MUL   = 4,
    parameter int LAT_FADD  = 3,
    parameter int LAT_FMUL  = 4,
    parameter int LAT_LOGIC = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    alu_seq_ctrl_if.slave    bus
`ifdef ALU_PERF_CNT_EN
    ,
    output logic      [31:0] perf_ops,
    output logic      [31:0] perf_busy
`endif
);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_req_ready;
    logic        r_alu_enable;
    logic [4:0]  r_alu_opcode;
    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic        r_res_valid;
    logic [31:0] r_res_data;
    logic        r_res_err;

    logic [3:0]  w_lat;
    logic        w_illegal;
    logic        w_accept;

    alu_lat_lookup #(
        .LAT_INT   (LAT_INT),
        .LAT_MUL   (LAT_MUL),
        .LAT_FADD  (LAT_FADD),
        .LAT_FMUL  (LAT_FMUL),
        .LAT_LOGIC (LAT_LOGIC)
    ) u_lat_lookup (
        .opcode  (bus.req_opcode),
        .lat     (w_lat),
        .illegal (w_illegal)
    );

    assign w_accept = (r_state == IDLE) && r_req_ready && bus.req_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 4'd0;
            r_req_ready  <= 1'b1;
            r_alu_enable <= 1'b0;
            r_alu_opcode <= 5'd0;
            r_alu_a      <= 32'd0;
            r_alu_b      <= 32'd0;
            r_res_valid  <= 1'b0;
            r_res_data   <= 32'd0;
            r_res_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        // Illegal opcodes never reach the ALU; report straight away.
                        if (w_illegal) begin
                            r_res_data  <= 32'd0;
                            r_res_err   <= 1'b1;
                            r_res_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_alu_opcode <= bus.req_opcode;
                            r_alu_a      <= bus.req_a;
                            r_alu_b      <= bus.req_b;
                            r_alu_enable <= 1'b1;
                            r_cnt        <= w_lat - 4'd1;
                            r_state      <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (r_cnt == 4'd0) begin
                        r_res_data   <= bus.alu_out;
                        r_res_err    <= 1'b0;
                        r_res_valid  <= 1'b1;
                        r_alu_enable <= 1'b0;
                        r_state      <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_req_ready  <= 1'b1;
                    r_alu_enable <= 1'b0;
                    r_res_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.alu_enable = r_alu_enable;
    assign bus.alu_opcode = r_alu_opcode;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_data   = r_res_data;
    assign bus.res_err    = r_res_err;

`ifdef ALU_PERF_CNT_EN
    logic [31:0] r_perf_ops;
    logic [31:0] r_perf_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_ops  <= 32'd0;
            r_perf_busy <= 32'd0;
        end else begin
            if (w_accept && !w_illegal) r_perf_ops  <= r_perf_ops + 32'd1;
            if (r_state != IDLE)        r_perf_busy <= r_perf_busy + 32'd1;
        end
    end

    assign perf_ops  = r_perf_ops;
    assign perf_busy = r_perf_busy;
`endif

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Issue/sequencing stage directly upstream of the non-pipelined 32-bit ALU. It accepts one operation per valid/ready handshake from the decode stage and drives the ALU opcode, operands and enable. Operands are held stable for the opcode class's fixed latency. It then captures the ALU result into a register and presents it downstream on a valid/ready handshake. Only one operation is in flight at a time.

Parameters:
LAT_INT, 1, cycles ALU needs for integer add/addc/sub/subb (opcodes 0-3)
LAT_MUL, 4, cycles for integer multiply (opcode 4)
LAT_FADD, 3, cycles for float add/sub (opcodes 5-6)
LAT_FMUL, 4, cycles for float multiply (opcode 7)
LAT_LOGIC, 1, cycles for logic/not/neg (opcodes 8-15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  upstream operation valid
req_ready  out  1  stage can accept an operation
req_opcode  in  5  ALU opcode; 0-15 legal, 16-31 illegal
req_a  in  32  operand A
req_b  in  32  operand B
alu_opcode  out  5  opcode to ALU
alu_a  out  32  operand A to ALU
alu_b  out  32  operand B to ALU
alu_enable  out  1  ALU decoder enable
alu_out  in  32  ALU result bus
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_data  out  32  captured result
res_err  out  1  result flagged illegal opcode

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst, with clock clk.
- Reset values: state=IDLE, req_ready=1, alu_enable=0, alu_opcode=0, alu_a=0, alu_b=0, res_valid=0, res_data=0, res_err=0, counter=0.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid at edge E0 with a legal opcode: latch opcode/a/b into the alu_* registers, set alu_enable=1, load counter=LAT(opcode)-1, go to EXEC.
  - On req_valid at E0 with an illegal opcode (>=16): alu_enable stays 0, res_data=0, res_err=1, go to DONE. res_valid is therefore 1 after E0.
- EXEC:
  - req_ready=0. alu_a, alu_b and alu_opcode are held constant, and alu_enable=1.
  - Each edge with counter!=0 decrements the counter.
  - At the edge where counter==0: res_data<=alu_out, res_err<=0, alu_enable<=0, go to DONE.
  - res_valid first high after edge E0+LAT.
- DONE:
  - res_valid=1; res_data and res_err are held.
  - On res_ready=1 at an edge: res_valid<=0, go to IDLE.
  - req_ready=0 in DONE, so no new request is accepted in the same cycle as a result handshake. Throughput is one op per LAT+2 cycles.
- alu_enable is never 1 outside EXEC. alu_* operands are unchanged from E0 until leaving EXEC.
- Counter is 4 bits. Every LAT_* must be in 1..15; elaboration-time check fails otherwise.
- rst asserted in any state, including mid-EXEC, aborts the operation: all outputs return to reset values on that edge and no result is presented.
- req_valid while req_ready=0 is ignored; upstream must hold its request.
- res_ready while res_valid=0 has no effect.

Optional Feature:
ALU_PERF_CNT_EN:
- Defined: adds outputs perf_ops (32-bit) and perf_busy (32-bit).
  - perf_ops increments on every accepted legal request.
  - perf_busy increments on every cycle in EXEC or DONE.
  - Both clear on rst and wrap modulo 2^32.
- Undefined: these ports and their registers do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD=0, OP_ADDC=1, OP_SUB=2, OP_SUBB=3, OP_MUL=4, OP_FADD=5, OP_FSUB=6, OP_FMUL=7, OP_AND=8, OP_OR=9, OP_XOR=10, OP_NAND=11, OP_NOR=12, OP_XNOR=13, OP_NOT=14, OP_NEG=15;
  - the state encoding IDLE=0, EXEC=1, DONE=2;
  - the opcode-class enumeration.
- One sub-module, alu_lat_lookup: combinational map from opcode to latency (4-bit) plus illegal flag, parameterised by the LAT_* values.

Test Plan:
- Add: opcode 0, a=5, b=7, ALU model returns a+b -> alu_enable high exactly 1 cycle, res_valid at E0+1, res_data=12, res_err=0.
- Multiply with operand hold: opcode 4, a=3, b=0xFFFF_FFFF, ALU model 4-cycle -> alu_a/alu_b stable for 4 cycles, res_data=0xFFFF_FFFD at E0+4, req_ready=0 throughout.
- Backpressure: opcode 8, a=0xF0F0_F0F0, b=0xFF00_FF00, res_ready held 0 for 5 cycles -> res_valid and res_data=0xF000_F000 held; the next req_valid is ignored until the handshake completes and IDLE is re-entered.
- Illegal opcode: opcode 20 -> alu_enable never asserts, res_valid at E0+1, res_data=0, res_err=1.
- Reset mid-EXEC: opcode 7 accepted, rst=1 at E0+2 -> all outputs at reset values after that edge, res_valid never rises; the next add completes normally.
- With ALU_PERF_CNT_EN defined: three legal ops (latencies 1, 4, 3) with immediate res_ready -> perf_ops=3, perf_busy=11.
